decode_controller: RTL and testbench

DECODE_CONTROLLER -- requirements
Module: decode_controller

---
 rtl/decode_controller.sv | 167 ++++++++++++++++
 tb/tb_decode_controller.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/decode_controller.sv
// ----------------------------------------------------------------------------
// decode_controller
//
// Takes one decoded packet per start request and writes it to the router
// arbiter.
//   - A rising edge on router_start_req (in IDLE) arms reception.
//   - The controller waits for decode_valid, captures {payload, dst_addr} and
//     requests a write from the arbiter.
//   - On grant it holds the request one more cycle, pulses router_done and
//     bumps pkt_count.
//   - If no grant arrives within TIMEOUT_CYCLES request cycles, it pulses
//     router_error instead and pkt_count is left unchanged.
//
// Parameters
//   DATA_WIDTH      payload width in bits
//   ADDR_WIDTH      router address width in bits
//   DATA_DFX_WIDTH  decoded packet width, {payload, dst_addr}
//   TIMEOUT_CYCLES  max request cycles without grant (1..65535)
//
// Ports
//   clk                in   sole clock, rising edge
//   rst                in   synchronous active-high reset
//   router_start_req   in   rising edge arms reception of one packet
//   router_busy        out  high while not IDLE
//   router_done        out  one-cycle pulse after a successful write
//   router_error       out  one-cycle pulse on grant timeout
//   pkt_count          out  successful writes, modulo 2^16
//   decode_valid       in   decoded packet present on data_dfx_recv
//   data_dfx_recv      in   {payload, dst_addr}
//   decode_ready       out  controller accepts a decoded packet
//   arbiter_write_req  out  write request to the arbiter
//   arbiter_write_gnt  in   arbiter grant
//   arbiter_dst_addr   out  captured destination address
//   data_arbiter_recv  out  captured payload
//
// State table
//   state      | meaning
//   IDLE       | waiting for a start edge
//   WAIT_PKT   | decode_ready high, waiting for decode_valid
//   WRITE_REQ  | arbiter_write_req high, waiting for grant or timeout
//   WRITE_HOLD | request held one extra cycle after grant
//   DONE       | router_done pulse, pkt_count increments
//   ERROR      | router_error pulse after timeout
// ----------------------------------------------------------------------------
module decode_controller #(
    parameter int DATA_WIDTH     = 1024,
    parameter int ADDR_WIDTH     = 10,
    parameter int DATA_DFX_WIDTH = DATA_WIDTH + ADDR_WIDTH,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      router_start_req,
    output logic                      router_busy,
    output logic                      router_done,
    output logic                      router_error,
    output logic [15:0]               pkt_count,
    input  logic                      decode_valid,
    input  logic [DATA_DFX_WIDTH-1:0] data_dfx_recv,
    output logic                      decode_ready,
    output logic                      arbiter_write_req,
    input  logic                      arbiter_write_gnt,
    output logic [ADDR_WIDTH-1:0]     arbiter_dst_addr,
    output logic [DATA_WIDTH-1:0]     data_arbiter_recv
);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        WAIT_PKT   = 3'd1,
        WRITE_REQ  = 3'd2,
        WRITE_HOLD = 3'd3,
        DONE       = 3'd4,
        ERROR      = 3'd5
    } state_t;

    // The wait counter reads 0 in the first request cycle, so it reaches this
    // value in the last allowed request cycle.
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t                  state_q, state_d;
    logic                    start_prev_q;
    logic [15:0]             wait_cnt_q, wait_cnt_d;
    logic [15:0]             pkt_count_q, pkt_count_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic                    start_edge;

    assign start_edge = router_start_req & ~start_prev_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            start_prev_q <= 1'b0;
            wait_cnt_q   <= 16'd0;
            pkt_count_q  <= 16'd0;
            addr_q       <= '0;
            data_q       <= '0;
        end else begin
            state_q      <= state_d;
            start_prev_q <= router_start_req;
            wait_cnt_q   <= wait_cnt_d;
            pkt_count_q  <= pkt_count_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        pkt_count_d = pkt_count_q;
        addr_d      = addr_q;
        data_d      = data_q;

        case (state_q)
            IDLE: begin
                if (start_edge) begin
                    state_d = WAIT_PKT;
                end
            end
            WAIT_PKT: begin
                if (decode_valid) begin
                    addr_d     = data_dfx_recv[ADDR_WIDTH-1:0];
                    data_d     = data_dfx_recv[DATA_DFX_WIDTH-1:ADDR_WIDTH];
                    wait_cnt_d = 16'd0;
                    state_d    = WRITE_REQ;
                end
            end
            WRITE_REQ: begin
                // Grant is checked first so it wins over a same-cycle timeout.
                if (arbiter_write_gnt) begin
                    state_d = WRITE_HOLD;
                end else if (wait_cnt_q == TIMEOUT_LAST) begin
                    state_d = ERROR;
                end else begin
                    wait_cnt_d = wait_cnt_q + 16'd1;
                end
            end
            WRITE_HOLD: begin
                state_d = DONE;
            end
            DONE: begin
                pkt_count_d = pkt_count_q + 16'd1;
                state_d     = IDLE;
            end
            ERROR: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        router_busy       = (state_q != IDLE);
        decode_ready      = (state_q == WAIT_PKT);
        arbiter_write_req = (state_q == WRITE_REQ) || (state_q == WRITE_HOLD);
        router_done       = (state_q == DONE);
        router_error      = (state_q == ERROR);
    end

    assign pkt_count         = pkt_count_q;
    assign arbiter_dst_addr  = addr_q;
    assign data_arbiter_recv = data_q;

endmodule

// File: tb/tb_decode_controller.sv
module tb_decode_controller;

    localparam int DW = 32;
    localparam int AW = 10;
    localparam int TO = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic           router_start_req;
    logic           router_busy;
    logic           router_done;
    logic           router_error;
    logic [15:0]    pkt_count;
    logic           decode_valid;
    logic [DW+AW-1:0] data_dfx_recv;
    logic           decode_ready;
    logic           arbiter_write_req;
    logic           arbiter_write_gnt;
    logic [AW-1:0]  arbiter_dst_addr;
    logic [DW-1:0]  data_arbiter_recv;

    decode_controller #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .DATA_DFX_WIDTH(DW + AW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .router_start_req(router_start_req),
        .router_busy(router_busy),
        .router_done(router_done),
        .router_error(router_error),
        .pkt_count(pkt_count),
        .decode_valid(decode_valid),
        .data_dfx_recv(data_dfx_recv),
        .decode_ready(decode_ready),
        .arbiter_write_req(arbiter_write_req),
        .arbiter_write_gnt(arbiter_write_gnt),
        .arbiter_dst_addr(arbiter_dst_addr),
        .data_arbiter_recv(data_arbiter_recv)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        rst, start, valid, gnt;
        logic [AW-1:0] addr_in;
        logic [DW-1:0] pay_in;
        logic        busy, ready, req, done, err;
        logic [15:0] cnt;
        logic [AW-1:0] addr;
        logic [DW-1:0] pay;
    } vec_t;

    vec_t vecs[$];
    int   errors = 0;
    int   checks = 0;

    task automatic add(input string name, input logic r, input logic s, input logic v,
                       input logic g, input logic [AW-1:0] ai, input logic [DW-1:0] pi,
                       input logic b, input logic rd, input logic rq, input logic dn,
                       input logic er, input logic [15:0] c, input logic [AW-1:0] a,
                       input logic [DW-1:0] p);
        vec_t t;
        t.name = name; t.rst = r; t.start = s; t.valid = v; t.gnt = g;
        t.addr_in = ai; t.pay_in = pi;
        t.busy = b; t.ready = rd; t.req = rq; t.done = dn; t.err = er;
        t.cnt = c; t.addr = a; t.pay = p;
        vecs.push_back(t);
    endtask

    task automatic check(input string name, input logic [62:0] act, input logic [62:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got busy/rdy/req/done/err=%b cnt=%h addr=%h pay=%h, want %b cnt=%h addr=%h pay=%h",
                     name, act[62:58], act[57:42], act[41:32], act[31:0],
                     exp[62:58], exp[57:42], exp[41:32], exp[31:0]);
        end
    endtask

    function automatic logic [62:0] outs();
        return {router_busy, decode_ready, arbiter_write_req, router_done, router_error,
                pkt_count, arbiter_dst_addr, data_arbiter_recv};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check1(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    localparam logic [DW-1:0] PA = 32'hA5A5A5A5;
    localparam logic [DW-1:0] PB = 32'hDEADBEEF;
    localparam logic [DW-1:0] PC = 32'hCAFEF00D;
    localparam logic [DW-1:0] PD = 32'h0F0F0F0F;
    localparam logic [DW-1:0] PE = 32'h5A5A5A5A;

    initial begin
        rst = 1'b0; router_start_req = 1'b0; decode_valid = 1'b0;
        arbiter_write_gnt = 1'b0; data_dfx_recv = '0;

        //   name          rst st vl gn addr_in  pay_in        bsy rdy req dn er cnt  addr    pay
        add("reset",        1, 0, 0, 0, 10'h000, 32'h0,        0, 0, 0, 0, 0, 16'd0, 10'h000, 32'h0);
        add("n_start",      0, 1, 0, 0, 10'h000, 32'h0,        1, 1, 0, 0, 0, 16'd0, 10'h000, 32'h0);
        add("n_capture",    0, 1, 1, 0, 10'h3C1, PA,           1, 0, 1, 0, 0, 16'd0, 10'h3C1, PA);
        add("n_req1",       0, 0, 0, 0, 10'h000, 32'h0,        1, 0, 1, 0, 0, 16'd0, 10'h3C1, PA);
        add("n_gnt",        0, 0, 0, 1, 10'h000, 32'h0,        1, 0, 1, 0, 0, 16'd0, 10'h3C1, PA);
        add("n_hold",       0, 0, 0, 0, 10'h000, 32'h0,        1, 0, 0, 1, 0, 16'd0, 10'h3C1, PA);
        add("n_idle",       0, 0, 0, 0, 10'h000, 32'h0,        0, 0, 0, 0, 0, 16'd1, 10'h3C1, PA);
        add("n_idle2",      0, 0, 0, 0, 10'h000, 32'h0,        0, 0, 0, 0, 0, 16'd1, 10'h3C1, PA);
        add("i_valid_idle", 0, 0, 1, 0, 10'h055, 32'h12345678, 0, 0, 0, 0, 0, 16'd1, 10'h3C1, PA);
        add("i_start",      0, 1, 0, 0, 10'h000, 32'h0,        1, 1, 0, 0, 0, 16'd1, 10'h3C1, PA);
        add("i_capture",    0, 0, 1, 0, 10'h2AA, PB,           1, 0, 1, 0, 0, 16'd1, 10'h2AA, PB);
        add("i_start_req",  0, 1, 1, 0, 10'h111, 32'h11111111, 1, 0, 1, 0, 0, 16'd1, 10'h2AA, PB);
        add("i_gnt",        0, 0, 0, 1, 10'h000, 32'h0,        1, 0, 1, 0, 0, 16'd1, 10'h2AA, PB);
        add("i_done",       0, 0, 0, 0, 10'h000, 32'h0,        1, 0, 0, 1, 0, 16'd1, 10'h2AA, PB);
        add("i_idle",       0, 0, 0, 0, 10'h000, 32'h0,        0, 0, 0, 0, 0, 16'd2, 10'h2AA, PB);
        add("i_not_queued", 0, 0, 0, 0, 10'h000, 32'h0,        0, 0, 0, 0, 0, 16'd2, 10'h2AA, PB);
        add("t_start",      0, 1, 0, 0, 10'h000, 32'h0,        1, 1, 0, 0, 0, 16'd2, 10'h2AA, PB);
        add("t_req1",       0, 0, 1, 0, 10'h001, PC,           1, 0, 1, 0, 0, 16'd2, 10'h001, PC);
        add("t_req2",       0, 0, 0, 0, 10'h000, 32'h0,        1, 0, 1, 0, 0, 16'd2, 10'h001, PC);
        add("t_req3",       0, 0, 0, 0, 10'h000, 32'h0,        1, 0, 1, 0, 0, 16'd2, 10'h001, PC);
        add("t_req4",       0, 0, 0, 0, 10'h000, 32'h0,        1, 0, 1, 0, 0, 16'd2, 10'h001, PC);
        add("t_error",      0, 0, 0, 0, 10'h000, 32'h0,        1, 0, 0, 0, 1, 16'd2, 10'h001, PC);
        add("t_idle",       0, 0, 0, 0, 10'h000, 32'h0,        0, 0, 0, 0, 0, 16'd2, 10'h001, PC);
        add("b_start",      0, 1, 0, 0, 10'h000, 32'h0,        1, 1, 0, 0, 0, 16'd2, 10'h001, PC);
        add("b_req1",       0, 0, 1, 0, 10'h3FF, PD,           1, 0, 1, 0, 0, 16'd2, 10'h3FF, PD);
        add("b_req2",       0, 0, 0, 0, 10'h000, 32'h0,        1, 0, 1, 0, 0, 16'd2, 10'h3FF, PD);
        add("b_req3",       0, 0, 0, 0, 10'h000, 32'h0,        1, 0, 1, 0, 0, 16'd2, 10'h3FF, PD);
        add("b_req4",       0, 0, 0, 0, 10'h000, 32'h0,        1, 0, 1, 0, 0, 16'd2, 10'h3FF, PD);
        add("b_gnt_last",   0, 0, 0, 1, 10'h000, 32'h0,        1, 0, 1, 0, 0, 16'd2, 10'h3FF, PD);
        add("b_done",       0, 0, 0, 0, 10'h000, 32'h0,        1, 0, 0, 1, 0, 16'd2, 10'h3FF, PD);
        add("b_idle",       0, 0, 0, 0, 10'h000, 32'h0,        0, 0, 0, 0, 0, 16'd3, 10'h3FF, PD);
        add("r_start",      0, 1, 0, 0, 10'h000, 32'h0,        1, 1, 0, 0, 0, 16'd3, 10'h3FF, PD);
        add("r_req",        0, 0, 1, 0, 10'h0AB, PA,           1, 0, 1, 0, 0, 16'd3, 10'h0AB, PA);
        add("r_reset",      1, 1, 0, 0, 10'h000, 32'h0,        0, 0, 0, 0, 0, 16'd0, 10'h000, 32'h0);
        add("r_held_start", 0, 1, 0, 0, 10'h000, 32'h0,        1, 1, 0, 0, 0, 16'd0, 10'h000, 32'h0);
        add("r_wait",       0, 0, 0, 0, 10'h000, 32'h0,        1, 1, 0, 0, 0, 16'd0, 10'h000, 32'h0);
        add("r_capture",    0, 0, 1, 0, 10'h155, PE,           1, 0, 1, 0, 0, 16'd0, 10'h155, PE);
        add("r_gnt",        0, 0, 0, 1, 10'h000, 32'h0,        1, 0, 1, 0, 0, 16'd0, 10'h155, PE);
        add("r_done",       0, 0, 0, 0, 10'h000, 32'h0,        1, 0, 0, 1, 0, 16'd0, 10'h155, PE);
        add("r_idle",       0, 0, 0, 0, 10'h000, 32'h0,        0, 0, 0, 0, 0, 16'd1, 10'h155, PE);

        @(negedge clk);
        foreach (vecs[i]) begin
            rst               = vecs[i].rst;
            router_start_req  = vecs[i].start;
            decode_valid      = vecs[i].valid;
            arbiter_write_gnt = vecs[i].gnt;
            data_dfx_recv     = {vecs[i].pay_in, vecs[i].addr_in};
            step();
            check(vecs[i].name, outs(),
                  {vecs[i].busy, vecs[i].ready, vecs[i].req, vecs[i].done, vecs[i].err,
                   vecs[i].cnt, vecs[i].addr, vecs[i].pay});
        end
        rst = 1'b0; router_start_req = 1'b0; decode_valid = 1'b0; arbiter_write_gnt = 1'b0;

        // Counter wrap: preload 0xFFFF, confirm IDLE holds it, then complete one packet.
        force dut.pkt_count_q = 16'hFFFF;
        #1;
        release dut.pkt_count_q;
        step();
        check1("wrap_preload", 32'(pkt_count), 32'h0000FFFF);

        router_start_req = 1'b1;
        step();
        router_start_req = 1'b0;
        check1("wrap_ready", 32'(decode_ready), 32'd1);
        decode_valid  = 1'b1;
        data_dfx_recv = {32'h87654321, 10'h2C3};
        step();
        decode_valid      = 1'b0;
        arbiter_write_gnt = 1'b1;
        begin
            int n;
            n = 0;
            while (router_done !== 1'b1 && n < 10) begin
                step();
                arbiter_write_gnt = 1'b0;
                n++;
            end
            check1("wrap_done_seen", 32'(router_done), 32'd1);
        end
        check1("wrap_addr", 32'(arbiter_dst_addr), 32'h2C3);
        check1("wrap_pay", data_arbiter_recv, 32'h87654321);
        step();
        check1("wrap_count", 32'(pkt_count), 32'h00000000);
        check1("wrap_idle", 32'(router_busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1);
    end

endmodule
